pc_gen_unit: RTL and testbench

PC_GEN_UNIT -- requirements
Module: pc_gen_unit

---
 rtl/pc_gen_unit.sv | 144 ++++++++++++++
 tb/tb_pc_gen_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_unit.sv
// Fetch program-counter generator: BOOT/RUN/HALT sequencing with prioritised trap/JALR/branch redirects.
// Optional redirect performance counter is enabled by defining PC_GEN_PERF_EN.
module pc_gen_unit #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] imm,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_pc,
  input  logic            jalr_en,
  input  logic [XLEN-1:0] jalr_base,
  input  logic            trap_req,
  input  logic            halt_req,
  input  logic            if_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] epc,
  output logic            misalign_err,
  output logic [31:0]     redirect_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state;

  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_target;

  logic            redir;
  logic [XLEN-1:0] redir_pc;
  logic            redir_mis;
  logic            epc_we;
  logic [XLEN-1:0] epc_val;

  assign br_target   = br_pc + (imm << 1);
  assign jalr_sum    = jalr_base + imm;
  assign jalr_target = {jalr_sum[XLEN-1:1], 1'b0};

  // Only the highest-priority request is acted on; the rest are simply dropped.
  always_comb begin
    redir     = 1'b0;
    redir_pc  = if_pc;
    redir_mis = 1'b0;
    epc_we    = 1'b0;
    epc_val   = epc;
    if (trap_req) begin
      redir    = 1'b1;
      redir_pc = TRAP_VECTOR;
      epc_we   = 1'b1;
      epc_val  = if_pc;
    end else if (jalr_en) begin
      redir = 1'b1;
      if (jalr_target[1]) begin
        redir_pc  = TRAP_VECTOR;
        redir_mis = 1'b1;
        epc_we    = 1'b1;
        epc_val   = jalr_base;
      end else begin
        redir_pc = jalr_target;
      end
    end else if (br_taken) begin
      redir = 1'b1;
      if (br_target[1]) begin
        redir_pc  = TRAP_VECTOR;
        redir_mis = 1'b1;
        epc_we    = 1'b1;
        epc_val   = br_pc;
      end else begin
        redir_pc = br_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      if_pc        <= RESET_VECTOR;
      if_valid     <= 1'b0;
      epc          <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      case (state)
        BOOT: begin
          state    <= RUN;
          if_valid <= 1'b1;
        end
        RUN, HALT: begin
          if (redir) begin
            if_pc        <= redir_pc;
            misalign_err <= redir_mis;
            if (epc_we) epc <= epc_val;
            // A redirect never enters HALT; it only keeps an existing halt alive.
            if (state == HALT && halt_req) begin
              state    <= HALT;
              if_valid <= 1'b0;
            end else begin
              state    <= RUN;
              if_valid <= 1'b1;
            end
          end else if (state == RUN) begin
            if (if_ready) if_pc <= if_pc + XLEN'(4);
            if (halt_req) begin
              state    <= HALT;
              if_valid <= 1'b0;
            end
          end else if (!halt_req) begin
            state    <= RUN;
            if_valid <= 1'b1;
          end
        end
        default: begin
          state    <= BOOT;
          if_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_GEN_PERF_EN
  logic [31:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (redir && (state == RUN || state == HALT)) begin
      cnt <= cnt + 32'd1;
    end
  end

  assign redirect_cnt = cnt;
`else
  assign redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed-vector bench for pc_gen_unit: a cycle model checked every negedge plus literal pins.
module tb_pc_gen_unit;

  localparam logic [63:0] TRAP = 64'h100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] imm, br_pc, jalr_base;
  logic        br_taken, jalr_en, trap_req, halt_req, if_ready;
  logic        if_valid, misalign_err;
  logic [63:0] if_pc, epc;
  logic [31:0] redirect_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_gen_unit dut (
    .clk(clk), .rst_n(rst_n), .imm(imm), .br_taken(br_taken), .br_pc(br_pc),
    .jalr_en(jalr_en), .jalr_base(jalr_base), .trap_req(trap_req), .halt_req(halt_req),
    .if_ready(if_ready), .if_valid(if_valid), .if_pc(if_pc), .epc(epc),
    .misalign_err(misalign_err), .redirect_cnt(redirect_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        hit;
    logic        bad;
    logic [63:0] pc;
    logic [63:0] ep;
  } redir_t;

  // mode: 0 = boot, 1 = running (fetching), 2 = halted
  int          m_mode = 0;
  logic [63:0] m_pc   = 64'h0;
  logic [63:0] m_epc  = 64'h0;
  logic        m_mis  = 1'b0;
  logic [31:0] m_cnt  = 32'h0;
  redir_t      r_now;

  function automatic redir_t decide(input logic [63:0] pc, input logic [63:0] cur_epc);
    redir_t      r;
    logic [63:0] t;
    r = '{hit: 1'b0, bad: 1'b0, pc: pc, ep: cur_epc};
    if (trap_req) begin
      r = '{hit: 1'b1, bad: 1'b0, pc: TRAP, ep: pc};
    end else if (jalr_en) begin
      t = (jalr_base + imm) & ~64'h1;
      r = t[1] ? '{hit: 1'b1, bad: 1'b1, pc: TRAP, ep: jalr_base}
               : '{hit: 1'b1, bad: 1'b0, pc: t, ep: cur_epc};
    end else if (br_taken) begin
      t = br_pc + imm * 64'd2;
      r = t[1] ? '{hit: 1'b1, bad: 1'b1, pc: TRAP, ep: br_pc}
               : '{hit: 1'b1, bad: 1'b0, pc: t, ep: cur_epc};
    end
    return r;
  endfunction

  always_comb r_now = decide(m_pc, m_epc);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_pc <= 64'h0; m_epc <= 64'h0; m_mis <= 1'b0; m_cnt <= 32'h0;
    end else if (m_mode == 0) begin
      m_mode <= 1; m_mis <= 1'b0;
    end else if (r_now.hit) begin
      m_pc  <= r_now.pc;
      m_epc <= r_now.ep;
      m_mis <= r_now.bad;
`ifdef PC_GEN_PERF_EN
      m_cnt <= m_cnt + 32'd1;
`endif
      m_mode <= (m_mode == 2 && halt_req) ? 2 : 1;
    end else begin
      m_mis <= 1'b0;
      if (m_mode == 1) begin
        if (if_ready) m_pc <= m_pc + 64'd4;
        if (halt_req) m_mode <= 2;
      end else if (!halt_req) begin
        m_mode <= 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_valid", {63'b0, if_valid}, {63'b0, m_mode == 1});
    chk("cyc_pc", if_pc, m_pc);
    chk("cyc_epc", epc, m_epc);
    chk("cyc_mis", {63'b0, misalign_err}, {63'b0, m_mis});
    chk("cyc_cnt", {32'b0, redirect_cnt}, {32'b0, m_cnt});
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    br_taken = 0; jalr_en = 0; trap_req = 0;
  endtask

  task automatic txn(input string what);
    $display("txn %-28s pc=%h valid=%0b epc=%h mis=%0b cnt=%0d",
             what, if_pc, if_valid, epc, misalign_err, redirect_cnt);
  endtask

  function automatic logic [31:0] perf(input logic [31:0] n);
`ifdef PC_GEN_PERF_EN
    return n;
`else
    return 32'd0 & n;
`endif
  endfunction

  initial begin
    rst_n = 0; imm = 0; br_pc = 0; jalr_base = 0;
    br_taken = 0; jalr_en = 0; trap_req = 0; halt_req = 0; if_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", if_pc, 64'h0);
    chk("rst_valid", {63'b0, if_valid}, 64'h0);
    rst_n = 1;
    @(negedge clk);
    chk("boot_valid", {63'b0, if_valid}, 64'h0);
    chk("boot_pc", if_pc, 64'h0);
    #4;
    tick(); chk("seq0", if_pc, 64'h0); chk("seq0_valid", {63'b0, if_valid}, 64'h1); txn("seq");
    tick(); chk("seq4", if_pc, 64'h4);
    tick(); chk("seq8", if_pc, 64'h8); txn("seq");

    if_ready = 0;
    repeat (3) tick();
    chk("stall_pc", if_pc, 64'h8); chk("stall_valid", {63'b0, if_valid}, 64'h1); txn("stall");
    if_ready = 1;
    tick(); chk("stall_release", if_pc, 64'hC);

    br_taken = 1; br_pc = 64'h10; imm = 64'h20;
    tick(); idle();
    chk("branch", if_pc, 64'h50); chk("branch_cnt", {32'b0, redirect_cnt}, {32'b0, perf(1)}); txn("branch");

    jalr_en = 1; jalr_base = 64'h1001; imm = 64'h3; br_taken = 1;
    tick(); idle();
    chk("jalr_over_br", if_pc, 64'h1004); txn("jalr+branch");

    br_taken = 1; br_pc = 64'h10; imm = 64'h1;
    tick(); idle();
    chk("br_mis_pc", if_pc, TRAP); chk("br_mis_pulse", {63'b0, misalign_err}, 64'h1);
    chk("br_mis_epc", epc, 64'h10); txn("branch misaligned");
    tick(); chk("mis_one_cycle", {63'b0, misalign_err}, 64'h0); chk("after_trap", if_pc, 64'h104);

    jalr_en = 1; jalr_base = 64'h2000; imm = 64'h2;
    tick(); idle();
    chk("jalr_mis_epc", epc, 64'h2000); chk("jalr_mis_pc", if_pc, TRAP); txn("jalr misaligned");

    jalr_en = 1; jalr_base = 64'h20; imm = 64'h0;
    tick(); idle();
    chk("jalr_0x20", if_pc, 64'h20);
    if_ready = 0; halt_req = 1;
    tick(); chk("halt_valid", {63'b0, if_valid}, 64'h0); chk("halt_pc", if_pc, 64'h20); txn("halt");
    trap_req = 1;
    tick(); idle();
    chk("halt_trap_pc", if_pc, TRAP); chk("halt_trap_epc", epc, 64'h20);
    chk("halt_trap_valid", {63'b0, if_valid}, 64'h0); txn("trap in halt");
    tick(); chk("halt_hold", if_pc, TRAP);
    br_taken = 1; br_pc = 64'h200; imm = 64'h10;
    tick(); idle();
    chk("halt_branch", if_pc, 64'h220); chk("halt_branch_valid", {63'b0, if_valid}, 64'h0);
    halt_req = 0;
    tick(); chk("unhalt_valid", {63'b0, if_valid}, 64'h1); chk("unhalt_pc", if_pc, 64'h220);
    if_ready = 1;
    tick(); chk("unhalt_seq", if_pc, 64'h224);

    trap_req = 1; jalr_en = 1; br_taken = 1; jalr_base = 64'h40; br_pc = 64'h10; imm = 64'h20;
    tick(); idle();
    chk("trap_prio_pc", if_pc, TRAP); chk("trap_prio_epc", epc, 64'h224);
    chk("trap_cnt", {32'b0, redirect_cnt}, {32'b0, perf(8)}); txn("trap over jalr+branch");

    if_ready = 0; halt_req = 1;
    tick(); chk("halt2_valid", {63'b0, if_valid}, 64'h0);
    br_taken = 1; br_pc = 64'h40; imm = 64'h0; if_ready = 1; halt_req = 0;
    #2 rst_n = 0;
    #1;
    chk("midhalt_rst_pc", if_pc, 64'h0); chk("midhalt_rst_epc", epc, 64'h0);
    chk("midhalt_rst_valid", {63'b0, if_valid}, 64'h0);
    chk("midhalt_rst_cnt", {32'b0, redirect_cnt}, 64'h0); txn("reset mid-halt");
    tick();
    rst_n = 1;
    tick(); chk("boot_ignores_br", if_pc, 64'h0); chk("boot_done_valid", {63'b0, if_valid}, 64'h1);
    idle();
    tick(); chk("post_rst_seq4", if_pc, 64'h4);
    tick(); chk("post_rst_seq8", if_pc, 64'h8); txn("post reset");

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
